// File: rtl/conv_result_drain_pkg.sv
// Shared constants and FSM encoding for the coprocessor result drain.
package conv_result_drain_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH = 16;
  localparam int unsigned R_WORDS    = 50176;
  localparam int unsigned L_WORDS    = 1600;
  localparam int unsigned FIFO_DEPTH = 2;

  localparam logic BANK_R = 1'b0;
  localparam logic BANK_L = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StFlush = 2'd2
  } drain_state_e;

endpackage

// File: rtl/drain_fifo2.sv
// Two-entry FIFO with occupancy count; a pop frees its slot for a push in the same cycle.
module drain_fifo2 #(
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count
);
  import conv_result_drain_pkg::*;

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 2'd1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/conv_result_drain.sv
// Streams a whole result-RAM bank out on a valid/ready port after each finish_* rising edge.
module conv_result_drain #(
  parameter int unsigned DATA_WIDTH = conv_result_drain_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = conv_result_drain_pkg::ADDR_WIDTH,
  parameter int unsigned R_WORDS    = conv_result_drain_pkg::R_WORDS,
  parameter int unsigned L_WORDS    = conv_result_drain_pkg::L_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  finish_R,
  input  logic                  finish_L,
  output logic                  en_R,
  output logic [ADDR_WIDTH-1:0] addr_R,
  input  logic [DATA_WIDTH-1:0] dout_R,
  output logic                  en_L,
  output logic [ADDR_WIDTH-1:0] addr_L,
  input  logic [DATA_WIDTH-1:0] dout_L,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  m_bank,
  output logic                  busy
);
  import conv_result_drain_pkg::*;

  localparam logic [ADDR_WIDTH:0] RCnt = R_WORDS[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] LCnt = L_WORDS[ADDR_WIDTH:0];

  drain_state_e        state_q;
  logic                fin_r_q, fin_l_q;
  logic                pend_r_q, pend_l_q;
  logic                cur_bank_q;
  logic [ADDR_WIDTH:0] addr_q;
  logic                push_q, push_last_q, push_bank_q;

  logic                rise_r, rise_l, start_r, start_l;
  logic [ADDR_WIDTH:0] words_cur;
  logic                pop, issue, credit_ok;
  logic [2:0]          occupancy;
  logic [1:0]          fifo_count;
  logic [DATA_WIDTH+1:0] fifo_wdata, fifo_rdata;

  assign rise_r    = finish_R && !fin_r_q;
  assign rise_l    = finish_L && !fin_l_q;
  assign start_r   = (state_q == StIdle) && pend_r_q;
  assign start_l   = (state_q == StIdle) && !pend_r_q && pend_l_q;
  assign words_cur = (cur_bank_q == BANK_L) ? LCnt : RCnt;

  assign pop       = m_valid && m_ready;
  // Credit counts the read still in flight; a beat leaving this cycle frees a slot.
  assign occupancy = {1'b0, fifo_count} + {2'b00, push_q};
  assign credit_ok = occupancy < (3'd2 + {2'b00, pop});
  assign issue     = (state_q == StDrain) && (addr_q < words_cur) && credit_ok;

  assign en_R   = issue && (cur_bank_q == BANK_R);
  assign en_L   = issue && (cur_bank_q == BANK_L);
  assign addr_R = (cur_bank_q == BANK_R) ? addr_q[ADDR_WIDTH-1:0] : '0;
  assign addr_L = (cur_bank_q == BANK_L) ? addr_q[ADDR_WIDTH-1:0] : '0;
  assign busy   = (state_q != StIdle);

  assign fifo_wdata = {push_last_q, push_bank_q, (push_bank_q == BANK_L) ? dout_L : dout_R};
  assign m_data     = fifo_rdata[DATA_WIDTH-1:0];
  assign m_bank     = fifo_rdata[DATA_WIDTH];
  assign m_last     = fifo_rdata[DATA_WIDTH+1];
  assign m_valid    = (fifo_count != 2'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      fin_r_q     <= 1'b0;
      fin_l_q     <= 1'b0;
      pend_r_q    <= 1'b0;
      pend_l_q    <= 1'b0;
      cur_bank_q  <= BANK_R;
      addr_q      <= '0;
      push_q      <= 1'b0;
      push_last_q <= 1'b0;
      push_bank_q <= BANK_R;
    end else begin
      fin_r_q <= finish_R;
      fin_l_q <= finish_L;
      // A new edge wins over the clear so a request arriving at drain start is not lost.
      if (rise_r) pend_r_q <= 1'b1;
      else if (start_r) pend_r_q <= 1'b0;
      if (rise_l) pend_l_q <= 1'b1;
      else if (start_l) pend_l_q <= 1'b0;

      push_q      <= issue;
      push_last_q <= issue && (addr_q == words_cur - 1'b1);
      push_bank_q <= cur_bank_q;

      unique case (state_q)
        StIdle: begin
          if (start_r || start_l) begin
            state_q    <= StDrain;
            cur_bank_q <= start_r ? BANK_R : BANK_L;
            addr_q     <= '0;
          end
        end
        StDrain: begin
          if (issue) addr_q <= addr_q + 1'b1;
          if (addr_q == words_cur) state_q <= StFlush;
        end
        StFlush: begin
          if (pop && m_last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  drain_fifo2 #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push_q),
    .wdata(fifo_wdata),
    .pop  (pop),
    .rdata(fifo_rdata),
    .count(fifo_count)
  );

endmodule

// File: tb/tb_conv_result_drain.sv
// Randomized self-checking bench: small-bank instance for the scenarios, full-size R bank run.
module tb_conv_result_drain;

  localparam int unsigned SmallR = 8;
  localparam int unsigned SmallL = 4;
  localparam int unsigned FullR  = 50176;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        finish_R = 1'b0, finish_L = 1'b0;
  logic        en_R, en_L;
  logic [15:0] addr_R, addr_L;
  logic [31:0] dout_R = '0, dout_L = '0;
  logic [31:0] m_data;
  logic        m_valid, m_last, m_bank, busy;
  logic        m_ready = 1'b0;

  logic        finish_f = 1'b0;
  logic        en_r_f, en_l_f;
  logic [15:0] addr_r_f, addr_l_f;
  logic [31:0] dout_r_f = '0, dout_l_f = '0;
  logic [31:0] m_data_f;
  logic        m_valid_f, m_last_f, m_bank_f, busy_f;
  logic        m_ready_f = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int en_r_cnt = 0;
  int en_l_cnt = 0;
  int full_idx = 0;
  int ready_mode = 0;

  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  int          got_cyc_q[$];
  logic        stall_prev = 1'b0;
  logic [33:0] stall_word = '0;
  logic        last_prev = 1'b0;

  always #5 clk = ~clk;

  conv_result_drain #(
    .DATA_WIDTH(32), .ADDR_WIDTH(16), .R_WORDS(SmallR), .L_WORDS(SmallL)
  ) dut (
    .clk(clk), .reset(reset), .finish_R(finish_R), .finish_L(finish_L),
    .en_R(en_R), .addr_R(addr_R), .dout_R(dout_R),
    .en_L(en_L), .addr_L(addr_L), .dout_L(dout_L),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .m_bank(m_bank), .busy(busy)
  );

  conv_result_drain dut_full (
    .clk(clk), .reset(reset), .finish_R(finish_f), .finish_L(1'b0),
    .en_R(en_r_f), .addr_R(addr_r_f), .dout_R(dout_r_f),
    .en_L(en_l_f), .addr_L(addr_l_f), .dout_L(dout_l_f),
    .m_data(m_data_f), .m_valid(m_valid_f), .m_ready(m_ready_f),
    .m_last(m_last_f), .m_bank(m_bank_f), .busy(busy_f)
  );

  // RAM models: data = addr + bank*1000, one cycle read latency.
  always @(posedge clk) begin
    if (en_R) dout_R <= 32'(addr_R);
    if (en_L) dout_L <= 32'(addr_L) + 32'd1000;
    if (en_r_f) dout_r_f <= 32'(addr_r_f);
    if (en_l_f) dout_l_f <= 32'(addr_l_f) + 32'd1000;
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (en_R) en_r_cnt++;
    if (en_L) en_l_cnt++;
    if (last_prev) check_eq("busy_after_last", 64'(busy), 64'd0);
    last_prev = 1'b0;
    if (stall_prev && m_valid) check_eq("hold_while_stalled", 64'({m_last, m_bank, m_data}),
                                        64'(stall_word));
    stall_prev = m_valid && !m_ready;
    stall_word = {m_last, m_bank, m_data};
    if (m_valid && m_ready) begin
      got_q.push_back({m_last, m_bank, m_data});
      got_cyc_q.push_back(cyc);
      last_prev = m_last;
    end
    if (m_valid_f && m_ready_f) begin
      check_eq("full_beat", 64'({m_last_f, m_bank_f, m_data_f}),
               64'({full_idx == int'(FullR - 1), 1'b0, 32'(full_idx)}));
      full_idx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic r, input logic l);
    finish_R = r;
    finish_L = l;
    tick();
    finish_R = 1'b0;
    finish_L = 1'b0;
  endtask

  // Reference: a bank drain yields every word of that bank once, in address order.
  task automatic add_stream(input logic bank);
    int words = bank ? int'(SmallL) : int'(SmallR);
    for (int i = 0; i < words; i++) begin
      exp_q.push_back({i == words - 1, bank, 32'(i) + (bank ? 32'd1000 : 32'd0)});
    end
  endtask

  task automatic expect_stream(input string tag, input bit b2b, input int budget);
    int n = 0;
    while ((got_q.size() < exp_q.size() || busy) && n < budget) begin
      tick();
      n++;
    end
    repeat (10) tick();
    check_eq({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_eq(tag, 64'(got_q[i]), 64'(exp_q[i]));
    end
    if (b2b && got_cyc_q.size() > 1) begin
      check_eq({tag, "_b2b"}, 64'(got_cyc_q[got_cyc_q.size()-1] - got_cyc_q[0]),
               64'(got_cyc_q.size() - 1));
    end
    got_q.delete();
    exp_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_data"}, 64'(m_data), 64'd0);
    check_eq({tag, "_ctrl"}, 64'({en_R, en_L, addr_R, addr_L, m_valid, m_last, m_bank, busy}),
             64'd0);
  endtask

  initial begin
    int n;
    #1 reset = 1'b1;
    #1 check_outputs_zero("reset");
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // 1: single R drain, full throughput
    ready_mode = 1;
    en_l_cnt = 0;
    pulse(1'b1, 1'b0);
    add_stream(1'b0);
    expect_stream("r_stream", 1'b1, 100);
    check_eq("r_no_en_l", 64'(en_l_cnt), 64'd0);

    // 2: L drain with random backpressure
    ready_mode = 2;
    en_r_cnt = 0;
    pulse(1'b0, 1'b1);
    add_stream(1'b1);
    expect_stream("l_stream", 1'b0, 200);
    check_eq("l_no_en_r", 64'(en_r_cnt), 64'd0);

    // 3: simultaneous requests, R first
    pulse(1'b1, 1'b1);
    add_stream(1'b0);
    add_stream(1'b1);
    expect_stream("both_stream", 1'b0, 300);

    // 4: level held high gives one drain; re-edge mid-drain queues one repeat
    ready_mode = 1;
    finish_R = 1'b1;
    repeat (100) tick();
    finish_R = 1'b0;
    add_stream(1'b0);
    expect_stream("held_stream", 1'b1, 50);
    pulse(1'b1, 1'b0);
    n = 0;
    while (got_q.size() < 3 && n < 50) begin
      tick();
      n++;
    end
    pulse(1'b1, 1'b0);
    add_stream(1'b0);
    add_stream(1'b0);
    expect_stream("repeat_stream", 1'b0, 200);

    // 5: reset after beat 3 aborts the drain
    ready_mode = 1;
    pulse(1'b1, 1'b0);
    n = 0;
    while (got_q.size() < 4 && n < 50) begin
      tick();
      n++;
    end
    reset = 1'b1;
    #1 check_outputs_zero("mid_reset");
    repeat (2) tick();
    reset = 1'b0;
    repeat (30) tick();
    check_eq("abort_count", 64'(got_q.size()), 64'd4);
    add_stream(1'b0);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check_eq("abort_beats", 64'(got_q[i]),
                                                            64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
    got_cyc_q.delete();

    // 6: stalled start, credit limits reads to the FIFO depth
    ready_mode = 0;
    en_r_cnt = 0;
    pulse(1'b1, 1'b0);
    repeat (20) tick();
    check_eq("stall_reads_le2", 64'(en_r_cnt <= 2), 64'd1);
    check_eq("stall_valid", 64'(m_valid), 64'd1);
    check_eq("stall_no_beats", 64'(got_q.size()), 64'd0);
    ready_mode = 2;
    add_stream(1'b0);
    expect_stream("stall_stream", 1'b0, 200);

    // Full-size R bank
    full_idx = 0;
    finish_f = 1'b1;
    tick();
    finish_f = 1'b0;
    n = 0;
    while ((full_idx < int'(FullR) || busy_f) && n < 60000) begin
      tick();
      n++;
    end
    check_eq("full_count", 64'(full_idx), 64'(FullR));
    check_eq("full_busy_low", 64'(busy_f), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
